// File: rtl/systolic_skew_feeder.sv
// Skewed A/B operand feeder for an N x N systolic PE array.
// Ports: i_clk, i_arst (async low), i_valid/o_ready tile handshake,
// i_aTile/i_bTile int8 tiles, o_doProcess array enable, o_row/o_col
// skewed buffers (element 0 feeds the array), o_done/i_ack result
// drain handshake, o_busy (not idle).
module systolic_skew_feeder #(
    parameter int N              = 8,
    parameter int COMPUTE_CYCLES = 3*N-2
) (
    input  logic                               i_clk,
    input  logic                               i_arst,
    input  logic                               i_valid,
    output logic                               o_ready,
    input  logic signed [N-1:0][N-1:0][7:0]    i_aTile,
    input  logic signed [N-1:0][N-1:0][7:0]    i_bTile,
    output logic                               o_doProcess,
    output logic signed [N-1:0][2*N-2:0][7:0]  o_row,
    output logic signed [N-1:0][2*N-2:0][7:0]  o_col,
    output logic                               o_done,
    input  logic                               i_ack,
    output logic                               o_busy
);

    localparam int L  = 2*N-1;
    localparam int CW = $clog2(COMPUTE_CYCLES+1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                          state;
    logic [CW-1:0]                   cnt;
    logic signed [N-1:0][L-1:0][7:0] row_q;
    logic signed [N-1:0][L-1:0][7:0] col_q;
    logic signed [N-1:0][L-1:0][7:0] row_ld;
    logic signed [N-1:0][L-1:0][7:0] col_ld;
    logic                            accept;
    logic                            last;

    // Row i is delayed by i slots, column j by j slots, so that
    // A[i][k] and B[k][j] meet at PE(i,j) in the same cycle.
    always_comb begin
        row_ld = '0;
        col_ld = '0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                row_ld[i][i+k] = i_aTile[i][k];
                col_ld[i][i+k] = i_bTile[k][i];
            end
        end
    end

    assign accept = (state == IDLE) && i_valid;
    assign last   = (cnt == CW'(COMPUTE_CYCLES-1));

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            state <= IDLE;
            cnt   <= '0;
            row_q <= '0;
            col_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        row_q <= row_ld;
                        col_q <= col_ld;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (last) begin
                        row_q <= '0;
                        col_q <= '0;
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                        for (int i = 0; i < N; i++) begin
                            row_q[i] <= {8'h00, row_q[i][L-1:1]};
                            col_q[i] <= {8'h00, col_q[i][L-1:1]};
                        end
                    end
                end
                DONE: begin
                    if (i_ack) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // All control outputs are decodes of the state register only.
    assign o_ready     = (state == IDLE);
    assign o_busy      = (state != IDLE);
    assign o_doProcess = (state == RUN);
    assign o_done      = (state == DONE);
    assign o_row       = row_q;
    assign o_col       = col_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder (N=8 and N=2 instances).
// Includes a behavioural PE-array model fed from element 0 of each buffer.
module tb_systolic_skew_feeder;

    logic clk = 1'b0;
    logic arst;

    logic v8, rdy8, dp8, done8, ack8, busy8;
    logic signed [7:0][7:0][7:0]  a8, b8;
    logic signed [7:0][14:0][7:0] row8, col8;

    logic v2, rdy2, dp2, done2, ack2, busy2;
    logic signed [1:0][1:0][7:0]  a2, b2;
    logic signed [1:0][2:0][7:0]  row2, col2;

    int n_chk = 0;
    int n_pass = 0;

    int ar[8][8];
    int br[8][8];
    int na[8][8];
    int nb[8][8];
    int cm[8][8];

    always #5 clk = ~clk;

    systolic_skew_feeder #(.N(8)) u8 (
        .i_clk(clk), .i_arst(arst), .i_valid(v8), .o_ready(rdy8),
        .i_aTile(a8), .i_bTile(b8), .o_doProcess(dp8),
        .o_row(row8), .o_col(col8), .o_done(done8),
        .i_ack(ack8), .o_busy(busy8)
    );

    systolic_skew_feeder #(.N(2), .COMPUTE_CYCLES(4)) u2 (
        .i_clk(clk), .i_arst(arst), .i_valid(v2), .o_ready(rdy2),
        .i_aTile(a2), .i_bTile(b2), .o_doProcess(dp2),
        .o_row(row2), .o_col(col2), .o_done(done2),
        .i_ack(ack2), .o_busy(busy2)
    );

    // Output-stationary PE array: a flows right, b flows down.
    always @(negedge clk) begin
        if (dp8) begin
            for (int i = 0; i < 8; i++) begin
                for (int j = 0; j < 8; j++) begin
                    if (j == 0) na[i][j] = int'($signed(row8[i][0]));
                    else        na[i][j] = ar[i][j-1];
                    if (i == 0) nb[i][j] = int'($signed(col8[j][0]));
                    else        nb[i][j] = br[i-1][j];
                    cm[i][j] += na[i][j] * nb[i][j];
                end
            end
            ar = na;
            br = nb;
        end
    end

    task automatic check(input string tag, input longint obs,
                         input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_model();
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                ar[i][j] = 0;
                br[i][j] = 0;
                cm[i][j] = 0;
            end
    endtask

    int er[2][3] = '{'{1, 2, 0}, '{0, 3, 4}};
    int ec[2][3] = '{'{5, 7, 0}, '{0, 6, 8}};
    int rs[2][4] = '{'{1, 2, 0, 0}, '{0, 3, 4, 0}};
    int cs[2][4] = '{'{5, 7, 0, 0}, '{0, 6, 8, 0}};

    initial begin
        int cyc, dpc, edges, bad, bad_r, bad_c, neg, pos, r;
        arst = 1'b0;
        v8 = 0; ack8 = 0; a8 = '0; b8 = '0;
        v2 = 0; ack2 = 0; a2 = '0; b2 = '0;
        clr_model();
        #3;
        check("rst_ready", rdy8, 1);
        check("rst_busy", busy8, 0);
        check("rst_dp", dp8, 0);
        check("rst_done", done8, 0);
        check("rst_rows_zero", row8 == '0, 1);
        check("rst_cols_zero", col8 == '0, 1);
        @(negedge clk);
        arst = 1'b1;

        // Reset in the middle of a RUN window.
        @(negedge clk);
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 8; k++) begin
                a8[i][k] = 8'd5;
                b8[i][k] = 8'd6;
            end
        v8 = 1;
        step();
        v8 = 0;
        repeat (5) step();
        check("mid_run_dp", dp8, 1);
        #2;
        arst = 1'b0;
        #1;
        check("async_dp", dp8, 0);
        check("async_done", done8, 0);
        check("async_busy", busy8, 0);
        check("async_ready", rdy8, 1);
        check("async_rows", row8 == '0, 1);
        check("async_cols", col8 == '0, 1);
        @(negedge clk);
        arst = 1'b1;
        repeat (5) step();
        check("post_rst_busy", busy8, 0);
        check("post_rst_dp", dp8, 0);
        check("post_rst_rows", row8 == '0, 1);

        // N=2 skew load and shift.
        @(negedge clk);
        a2[0][0] = 8'd1; a2[0][1] = 8'd2; a2[1][0] = 8'd3; a2[1][1] = 8'd4;
        b2[0][0] = 8'd5; b2[0][1] = 8'd6; b2[1][0] = 8'd7; b2[1][1] = 8'd8;
        v2 = 1;
        step();
        v2 = 0;
        for (int i = 0; i < 2; i++)
            for (int p = 0; p < 3; p++) begin
                check($sformatf("ld_row%0d_%0d", i, p),
                      $signed(row2[i][p]), er[i][p]);
                check($sformatf("ld_col%0d_%0d", i, p),
                      $signed(col2[i][p]), ec[i][p]);
            end
        for (int c = 0; c < 4; c++) begin
            check($sformatf("seq_dp_c%0d", c), dp2, 1);
            for (int i = 0; i < 2; i++) begin
                check($sformatf("seq_row%0d_c%0d", i, c),
                      $signed(row2[i][0]), rs[i][c]);
                check($sformatf("seq_col%0d_c%0d", i, c),
                      $signed(col2[i][0]), cs[i][c]);
            end
            step();
        end
        check("n2_done", done2, 1);
        check("n2_dp_off", dp2, 0);
        check("n2_rows_clr", row2 == '0, 1);
        @(negedge clk);
        ack2 = 1;
        step();
        ack2 = 0;
        check("n2_ready", rdy2, 1);
        check("n2_done_drop", done2, 0);

        // Valid held through RUN and DONE with a second tile.
        @(negedge clk);
        v2 = 1;
        step();
        a2[0][0] = 8'd9;  a2[0][1] = 8'd10; a2[1][0] = 8'd11; a2[1][1] = 8'd12;
        b2[0][0] = 8'd13; b2[0][1] = 8'd14; b2[1][0] = 8'd15; b2[1][1] = 8'd16;
        cyc = 0;
        bad = 0;
        while (!done2 && cyc < 20) begin
            if (rdy2) bad++;
            cyc++;
            step();
        end
        check("hs_run_len", cyc, 4);
        check("hs_ready_low", bad, 0);
        step();
        step();
        check("hs_done_hold", done2, 1);
        check("hs_not_captured", row2 == '0, 1);
        @(negedge clk);
        ack2 = 1;
        step();
        ack2 = 0;
        check("hs_idle_ready", rdy2, 1);
        check("hs_idle_busy", busy2, 0);
        step();
        v2 = 0;
        check("hs_cap_dp", dp2, 1);
        check("hs_cap_r00", $signed(row2[0][0]), 9);
        check("hs_cap_r12", $signed(row2[1][2]), 12);
        check("hs_cap_c01", $signed(col2[0][1]), 15);
        check("hs_cap_c12", $signed(col2[1][2]), 16);
        cyc = 0;
        while (!done2 && cyc < 20) begin
            cyc++;
            step();
        end
        check("hs_done2", done2, 1);
        @(negedge clk);
        ack2 = 1;
        step();
        ack2 = 0;

        // N=8 timing plus array integration.
        @(negedge clk);
        arst = 1'b0;
        #1;
        arst = 1'b1;
        clr_model();
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 8; k++) begin
                a8[i][k] = (i == k) ? 8'd1 : 8'd0;
                b8[i][k] = 8'(i*8 + k);
            end
        v8 = 1;
        step();
        v8 = 0;
        edges = 1;
        dpc = 0;
        while (!done8 && edges < 60) begin
            if (dp8) dpc++;
            step();
            edges++;
        end
        check("t_dp_cycles", dpc, 22);
        check("t_done_edges", edges, 23);
        check("t_done", done8, 1);
        repeat (4) step();
        check("t_done_hold", done8, 1);
        check("t_ready_low", rdy8, 0);
        @(negedge clk);
        ack8 = 1;
        step();
        ack8 = 0;
        check("t_ready_back", rdy8, 1);
        check("t_done_drop", done8, 0);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                check($sformatf("arr_c%0d_%0d", i, j), cm[i][j], i*8 + j);

        // Signed extremes.
        @(negedge clk);
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 8; k++) begin
                a8[i][k] = 8'h80;
                b8[i][k] = 8'h7F;
            end
        v8 = 1;
        step();
        v8 = 0;
        check("sgn_first", $signed(row8[0][0]), -128);
        bad_r = 0; bad_c = 0; neg = 0; pos = 0;
        for (int c = 0; c < 22; c++) begin
            for (int i = 0; i < 8; i++) begin
                r = $signed(row8[i][0]);
                if (r == -128) neg++;
                else if (r != 0) bad_r++;
                r = $signed(col8[i][0]);
                if (r == 127) pos++;
                else if (r != 0) bad_c++;
            end
            step();
        end
        check("sgn_row_bad", bad_r, 0);
        check("sgn_col_bad", bad_c, 0);
        check("sgn_row_cnt", neg, 64);
        check("sgn_col_cnt", pos, 64);
        check("sgn_done", done8, 1);
        @(negedge clk);
        ack8 = 1;
        step();
        ack8 = 0;
        check("sgn_idle", rdy8, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
